// File: rtl/sif_xa_arbiter_pkg.sv
// Shared types and helpers for the SIF external-access arbiter.
// rr_pick is sized for the largest supported requester count and masked by n.
package sif_arb_pkg;

  localparam int DEF_AW  = 16;
  localparam int DEF_DW  = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr+1, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !res.found && valid[j[2:0]]) begin
        res.found = 1'b1;
        res.idx   = j[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sif_xa_arbiter_if.sv
// SIF external-access bus. The arbiter is the master and the only driver
// of address, write data and strobes; the slave returns read data.
interface sif_xa_if
  import sif_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [DW-1:0] xa_data_rd;

  modport master (output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
                  input  xa_data_rd);
  modport slave  (input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
                  output xa_data_rd);
endinterface

// File: rtl/sif_xa_arbiter_rr_picker.sv
// Combinational round-robin selector: lowest-distance valid requester
// after the pointer, wrapping at N.
module sif_rr_picker
  import sif_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = 2
)(
  input  logic [N-1:0]  i_valid,
  input  logic [OW-1:0] i_ptr,
  output logic [OW-1:0] o_idx,
  output logic          o_found
);
  pick_t              w_pick;
  logic [MAX_REQ-1:0] w_valid;

  always_comb begin
    w_valid         = '0;
    w_valid[N-1:0]  = i_valid;
    w_pick          = rr_pick(w_valid, 3'(i_ptr), N);
    o_idx           = OW'(w_pick.idx);
    o_found         = w_pick.found;
  end
endmodule

// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter sharing one SIF xa bus between N_REQ single-word
// requesters, with bounded write bursts and read-data return routing.
module sif_xa_arbiter
  import sif_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 4,
  localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_wr,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  sif_xa_if.master           xa,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output state_e             dbg_state
);
  // Handshake: a requester holds req_valid (and its fields) steady until the
  // cycle req_ready pulses for it; that cycle is the transfer. rsp_valid is a
  // one-cycle strobe with no back-pressure.

  state_e          r_state;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;
  logic [7:0]      r_burst_cnt;
  logic [2:0]      r_wait_cnt;
  logic [AW-1:0]   r_xa_addr;
  logic [DW-1:0]   r_xa_wdata;
  logic            r_xa_wr_s;
  logic            r_xa_rd_s;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;

  logic [OW-1:0]   w_pick_idx;
  logic            w_pick_found;
  logic            w_open;
  logic            w_burst;
  logic [OW-1:0]   w_win;
  logic            w_accept;
  logic            w_win_wr;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic [N_REQ-1:0] w_owner_oh;

  sif_rr_picker #(.N(N_REQ), .OW(OW)) u_picker (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    // XFER only reopens arbitration when the strobe in flight is a write.
    w_open      = (r_state == IDLE) || (r_state == RESP) ||
                  ((r_state == XFER) && r_xa_wr_s);
    w_burst     = (r_state == XFER) && r_xa_wr_s &&
                  req_valid[r_owner] && req_wr[r_owner] &&
                  (32'(r_burst_cnt) < 32'(BURST_MAX - 1));
    w_win       = w_burst ? r_owner : w_pick_idx;
    w_accept    = !rst && w_open && (w_burst || w_pick_found);
    w_win_wr    = req_wr[w_win];
    w_win_addr  = req_addr[int'(w_win)*AW +: AW];
    w_win_wdata = req_wdata[int'(w_win)*DW +: DW];
    w_owner_oh  = N_REQ'(1) << r_owner;
    req_ready   = w_accept ? (N_REQ'(1) << w_win) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= OW'(N_REQ - 1);
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_wait_cnt  <= '0;
      r_xa_addr   <= '0;
      r_xa_wdata  <= '0;
      r_xa_wr_s   <= 1'b0;
      r_xa_rd_s   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_state     <= XFER;
        r_xa_addr   <= w_win_addr;
        r_xa_wdata  <= w_win_wdata;
        r_xa_wr_s   <= w_win_wr;
        r_xa_rd_s   <= !w_win_wr;
        r_owner     <= w_win;
        r_ptr       <= w_win;
        r_burst_cnt <= w_burst ? r_burst_cnt + 8'd1 : 8'd0;
      end else begin
        case (r_state)
          XFER: begin
            r_xa_wr_s <= 1'b0;
            r_xa_rd_s <= 1'b0;
            if (r_xa_rd_s) begin
              r_state    <= RD_WAIT;
              r_wait_cnt <= 3'(RD_LAT - 1);
            end else begin
              r_state <= IDLE;
            end
          end
          RD_WAIT: begin
            if (r_wait_cnt == 3'd0) begin
              r_rsp_rdata <= xa.xa_data_rd;
              r_rsp_valid <= w_owner_oh;
              r_state     <= RESP;
            end else begin
              r_wait_cnt <= r_wait_cnt - 3'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign xa.xa_addr    = r_xa_addr;
  assign xa.xa_data_wr = r_xa_wdata;
  assign xa.xa_wr_s    = r_xa_wr_s;
  assign xa.xa_rd_s    = r_xa_rd_s;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign owner         = r_owner;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;

endmodule

// File: doc/sif_xa_arbiter.md
Name: sif_xa_arbiter

Overview:
- Shares the single SIF external-access bus (xa_*) between N_REQ independent requesters.
- Each requester issues single-word read or write transactions.
- Arbitration is round-robin with a bounded write-burst hold; read data is routed back to the issuing requester.
- Sits between testbench/agent-side transaction sources and the DUT's xa port. It is the only driver of xa_addr, xa_data_wr, xa_wr_s and xa_rd_s.

Parameters:
- N_REQ, 4, number of requesters (1..8).
- AW, 16, xa address width.
- DW, 16, xa data width.
- RD_LAT, 2, cycles from the xa_rd_s cycle to the cycle xa_data_rd is valid (1..7).
- BURST_MAX, 4, max consecutive writes granted to one owner before arbitration is forced (1 = no burst).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester transaction request; held until accepted.
- req_wr  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  in  N_REQ*DW  flattened write data, same packing.
- req_ready  out  N_REQ  one-hot accept pulse, combinational.
- rsp_valid  out  N_REQ  one-hot, one-cycle read-response strobe.
- rsp_rdata  out  DW  read data, valid with any rsp_valid bit.
- xa_addr  out  AW  bus address.
- xa_data_wr  out  DW  bus write data.
- xa_wr_s  out  1  write strobe.
- xa_rd_s  out  1  read strobe.
- xa_data_rd  in  DW  bus read data.
- owner  out  $clog2(N_REQ) (min 1)  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - All xa_* outputs, rsp_valid, rsp_rdata, owner and burst_cnt go to 0.
  - The round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
  - Reset mid-read drops the transaction; no rsp_valid follows.
- States: IDLE, XFER, RD_WAIT, RESP.
- Accept window: arbitration is open in IDLE, RESP, and XFER when the XFER carries a write.
- Winner selection:
  - Winner = first req_valid at or after ptr+1, modulo N_REQ.
  - Burst exception: in XFER-write, if owner's req_valid=1, owner's req_wr=1, and burst_cnt < BURST_MAX-1, the owner wins regardless of the pointer.
- Acceptance at cycle t:
  - req_ready[winner]=1 combinationally in cycle t.
  - Registered at the edge: xa_addr, xa_data_wr, xa_wr_s=req_wr, xa_rd_s=!req_wr, owner=winner, ptr=winner.
  - Next state is XFER.
  - burst_cnt increments if the winner equals the previous owner and this is a burst continuation; otherwise it resets to 0.
- XFER (cycle t+1): strobe high for exactly this cycle.
  - Write: arbitrate again. If there is a winner, stay in XFER (back-to-back strobes, zero bubbles); otherwise go to IDLE with strobes 0.
  - Read: strobes go to 0 and the state moves to RD_WAIT, with wait_cnt loaded to RD_LAT-1.
- RD_WAIT: decrement wait_cnt each cycle.
  - In the cycle where wait_cnt==0, i.e. cycle t+1+RD_LAT, register rsp_rdata <= xa_data_rd and go to RESP.
  - If RD_LAT==1, RD_WAIT lasts one cycle.
- RESP: rsp_valid[owner]=1 for one cycle (cycle t+2+RD_LAT); arbitration is open in the same cycle.
- Outside the accept window, req_ready=0 and at most one xa transaction is outstanding.
- xa_addr and xa_data_wr hold their last values when the strobes are 0.
- xa_wr_s and xa_rd_s are never high together.
- N_REQ=1: the pointer is trivial and the requester is always the winner when valid.
- The arbiter does not check requester protocol: a requester must not drop req_valid before its req_ready pulse.

Decomposition:
- Package sif_arb_pkg:
  - typedef enum state_e {IDLE, XFER, RD_WAIT, RESP}.
  - Localparams for default AW/DW.
  - Function rr_pick(valid, ptr) returning the winner index and a found flag.
- Sub-module sif_rr_picker:
  - Purely combinational round-robin priority selector, parameterised by N.
  - Reused by the sif monitor scoreboard model.

Test Plan:
- Single write: after reset, req0 write addr=0x0010 data=0xBEEF at cycle t -> req_ready[0] at t; xa_wr_s=1, xa_addr=0x0010, xa_data_wr=0xBEEF at t+1 only; busy=0 at t+2.
- Single read, RD_LAT=2: req2 read addr=0x0040, slave drives 0x1234 in the strobe cycle+2 -> xa_rd_s at t+1; rsp_valid[2]=1 with rsp_rdata=0x1234 at t+4; no other rsp bits.
- Round-robin: all four requesters hold writes continuously, BURST_MAX=1 -> owner sequence 0,1,2,3,0; one strobe per cycle, no gaps.
- Burst limit: req1 streams 6 writes, req3 also requests, BURST_MAX=4 -> four consecutive req1 strobes, then one req3 strobe, then the remaining req1 writes.
- Read blocks accepts: req0 read then req1 write -> req_ready[1] not before the RESP cycle of req0; req1's write strobe lands in the cycle after that RESP cycle.
- Reset mid-read: rst=1 during RD_WAIT -> next cycle all outputs 0 and state IDLE; no rsp_valid is ever issued for that read; the first post-reset grant goes to requester 0.
